// File: rtl/food_eat_ctrl_pkg.sv
// Shared game definitions: food map geometry and the eat-controller FSM encoding.
// The display-to-map-index logic uses the same geometry constants.
package food_eat_ctrl_pkg;

    localparam int GAME_MAP_W = 80;
    localparam int GAME_MAP_H = 60;
    localparam int GAME_X_W   = 7;
    localparam int GAME_Y_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WT   = 3'd2,
        ST_CHK  = 3'd3,
        ST_WR   = 3'd4
    } eat_state_e;

endpackage

// File: rtl/food_eat_ctrl_rr_arbiter.sv
// N-way round-robin arbiter with one-hot grant; the pointer moves to the
// granted channel only when the grant is accepted.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         accept_i,
    output logic [N-1:0] grant_o
);

    logic [IW-1:0] last_q;
    logic [IW-1:0] grant_idx;
    logic          found;

    // Two passes: channels above the last winner first, then wrap around.
    always_comb begin
        grant_o   = '0;
        grant_idx = last_q;
        found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (j > int'(last_q))) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                grant_idx  = IW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j] && (j <= int'(last_q))) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                grant_idx  = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else if (accept_i && found) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/food_eat_ctrl.sv
// Food eat controller: arbitrates eater channels and performs one read-modify-write
// per eat on the single-port food RAM, tracking score, remaining food and level clear.
module food_eat_ctrl
    import food_eat_ctrl_pkg::*;
#(
    parameter int MAP_W   = GAME_MAP_W,
    parameter int MAP_H   = GAME_MAP_H,
    parameter int X_W     = GAME_X_W,
    parameter int Y_W     = GAME_Y_W,
    parameter int N_EAT   = 2,
    parameter int SCORE_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_EAT-1:0]       eat_req,
    input  logic [N_EAT*X_W-1:0]   eat_x,
    input  logic [N_EAT*Y_W-1:0]   eat_y,
    output logic [N_EAT-1:0]       eat_ack,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [Y_W-1:0]         mem_addr,
    output logic [MAP_W-1:0]       mem_wdata,
    input  logic [MAP_W-1:0]       mem_rdata,
    input  logic                   load_total,
    input  logic [SCORE_W-1:0]     food_total,
    input  logic                   score_clr,
    output logic [SCORE_W-1:0]     score,
    output logic [SCORE_W-1:0]     food_left,
    output logic                   food_eaten,
    output logic [N_EAT-1:0]       eaten_ch,
    output logic                   level_clear,
    output logic                   busy,
    output logic [2:0]             dbg_state
);

    eat_state_e         state_q, state_d;
    logic [N_EAT-1:0]   ch_q, ch_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [MAP_W-1:0]   row_q, row_d;
    logic               oor_q, oor_d;
    logic               dwell_q, dwell_d;
    logic [SCORE_W-1:0] score_q, food_left_q;
    logic               zero_hit_q, level_clear_q;

    logic [N_EAT-1:0]   grant;
    logic               accept;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic               sel_oor;
    logic               eat_fire;

    assign accept = (state_q == ST_IDLE) && (|eat_req) && !load_total;

    rr_arbiter #(.N(N_EAT)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (eat_req),
        .accept_i (accept),
        .grant_o  (grant)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int c = 0; c < N_EAT; c++) begin
            if (grant[c]) begin
                sel_x = eat_x[c*X_W +: X_W];
                sel_y = eat_y[c*Y_W +: Y_W];
            end
        end
        sel_oor = (int'(sel_x) >= MAP_W) || (int'(sel_y) >= MAP_H);
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        x_d       = x_q;
        y_d       = y_q;
        row_d     = row_q;
        oor_d     = oor_q;
        dwell_d   = dwell_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        eat_ack   = '0;
        eat_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ch_d    = grant;
                    x_d     = sel_x;
                    y_d     = sel_y;
                    oor_d   = sel_oor;
                    dwell_d = 1'b0;
                    state_d = sel_oor ? ST_CHK : ST_RD;
                end
            end
            ST_RD: begin
                mem_en   = 1'b1;
                mem_addr = y_q;
                state_d  = ST_WT;
            end
            ST_WT: state_d = ST_CHK;
            ST_CHK: begin
                // Out-of-range ops sit in CHK for two cycles so their ack lands 2 cycles after grant.
                if (oor_q) begin
                    if (!dwell_q) begin
                        dwell_d = 1'b1;
                    end else begin
                        eat_ack = ch_q;
                        state_d = ST_IDLE;
                    end
                end else begin
                    row_d = mem_rdata;
                    if (mem_rdata[x_q]) begin
                        state_d = ST_WR;
                    end else begin
                        eat_ack = ch_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = y_q;
                mem_wdata = row_q & ~(MAP_W'(1) << x_q);
                eat_ack   = ch_q;
                eat_fire  = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            oor_q   <= 1'b0;
            dwell_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            oor_q   <= oor_d;
            dwell_q <= dwell_d;
        end
    end

    // level_clear follows one cycle after food_left reaches zero by a decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q       <= '0;
            food_left_q   <= '0;
            zero_hit_q    <= 1'b0;
            level_clear_q <= 1'b0;
        end else begin
            if (score_clr) begin
                score_q <= '0;
            end else if (eat_fire && (score_q != '1)) begin
                score_q <= score_q + SCORE_W'(1);
            end
            if (load_total && (state_q == ST_IDLE)) begin
                food_left_q   <= food_total;
                zero_hit_q    <= 1'b0;
                level_clear_q <= 1'b0;
            end else begin
                zero_hit_q <= eat_fire && (food_left_q == SCORE_W'(1));
                if (eat_fire && (food_left_q != '0)) begin
                    food_left_q <= food_left_q - SCORE_W'(1);
                end
                if (zero_hit_q) begin
                    level_clear_q <= 1'b1;
                end
            end
        end
    end

    assign score       = score_q;
    assign food_left   = food_left_q;
    assign level_clear = level_clear_q;
    assign food_eaten  = eat_fire;
    assign eaten_ch    = eat_fire ? ch_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

endmodule

// File: doc/food_eat_ctrl.md
FOOD_EAT_CTRL -- requirements
Module: food_eat_ctrl

Interface
REQ-001 SHALL have parameter MAP_W, default 80, meaning food columns per map row (bits per memory word).
REQ-002 SHALL have parameter MAP_H, default 60, meaning food map rows (memory depth).
REQ-003 SHALL have parameter X_W, default 7, meaning column index width; Y_W, default 6, meaning row index width.
REQ-004 SHALL have parameter N_EAT, default 2, meaning number of eater channels (pacman, player 2 / AI).
REQ-005 SHALL have parameter SCORE_W, default 16, meaning score and food-count width.
REQ-006 SHALL have ports: clk input 1 system clock; rst_n input 1 asynchronous active-low reset.
REQ-007 SHALL have ports: eat_req input N_EAT per-channel eat request (level, held until ack); eat_x input N_EAT*X_W packed column indices; eat_y input N_EAT*Y_W packed row indices; eat_ack output N_EAT one-cycle completion pulse per channel.
REQ-008 SHALL have ports: mem_en output 1; mem_we output 1; mem_addr output Y_W; mem_wdata output MAP_W; mem_rdata input MAP_W, forming a single-port food RAM master with 1-cycle registered read latency.
REQ-009 SHALL have ports: load_total input 1 pulse; food_total input SCORE_W; score_clr input 1 pulse; score output SCORE_W; food_left output SCORE_W; food_eaten output 1 pulse; eaten_ch output N_EAT one-hot; level_clear output 1; busy output 1.

Function
REQ-010 SHALL implement FSM states IDLE, RD, WT, CHK, WR; one eat operation at a time, read-modify-write on a single row.
REQ-011 SHALL, in IDLE with any eat_req high and no load_total, grant one channel by round-robin starting after the last granted channel (channel 0 first after reset), latching its x/y.
REQ-012 SHALL, if latched x >= MAP_W or y >= MAP_H, go IDLE->CHK without memory access and ack with no food eaten.
REQ-013 SHALL in RD drive mem_en=1, mem_we=0, mem_addr=y; in WT wait one cycle; in CHK capture mem_rdata.
REQ-014 SHALL in CHK go to WR if bit x of row is 1, else pulse eat_ack for the channel and return to IDLE.
REQ-015 SHALL in WR drive mem_en=1, mem_we=1, mem_addr=y, mem_wdata=row with bit x cleared, all other bits unchanged; pulse eat_ack, food_eaten and eaten_ch for that channel; return to IDLE.
REQ-016 SHALL give latency grant-to-ack of 4 cycles (eaten) or 3 cycles (empty cell), 2 cycles for out-of-range.
REQ-017 SHALL increment score by 1 per eaten cell, saturating at 2^SCORE_W-1; score_clr sets score to 0 with priority over increment.
REQ-018 SHALL decrement food_left per eaten cell, never below 0; load_total in IDLE sets food_left=food_total and clears level_clear; load_total outside IDLE is ignored.
REQ-019 SHALL set level_clear the cycle after food_left becomes 0 through a decrement and hold it until load_total; eat requests while level_clear=1 are still serviced.
REQ-020 SHALL hold busy=1 in every state except IDLE; mem_en=0 in IDLE, WT, CHK.
REQ-021 SHALL serialise two channels on the same cell: second channel reads the already-cleared row and acks without food_eaten.
REQ-022 SHALL not drop a request deasserted before ack; the latched operation completes, ack is still pulsed.

Reset
REQ-023 SHALL on rst_n=0 asynchronously force state IDLE, round-robin pointer to channel N_EAT-1, score=0, food_left=0, level_clear=0, all pulses and mem_en/mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 SHALL abandon an in-flight RMW on reset; a write not yet in WR is not issued.

Structure
REQ-025 SHALL take MAP_W, MAP_H, X_W, Y_W defaults and FSM state encodings from the shared game package used by the display-to-map-index logic.
REQ-026 SHALL place the round-robin arbiter in one sub-module rr_arbiter (N-way, one-hot grant, advance on accept).

Verification
REQ-027 Row 5 = all ones, ch0 req x=3,y=5 -> WR writes row 5 with bit 3 cleared, score 0->1, food_left 10->9, ack on 4th cycle after grant.
REQ-028 Same cell re-requested by ch0 -> no write, ack after 3 cycles, score stays 1.
REQ-029 ch0 and ch1 both req x=7,y=2 same cycle, bit set -> ch0 eats, ch1 acks empty, eaten_ch=01 once.
REQ-030 food_total=1 loaded, one eat -> food_left=0, level_clear=1 next cycle; load_total=3 -> level_clear=0, food_left=3.
REQ-031 ch1 req x=85,y=2 -> no mem_en, ack after 2 cycles, score unchanged.
REQ-032 rst_n low during RD of a valid eat -> no write, score=0, busy=0, next grant goes to ch0.
